nes_button_capture: RTL
=======================

// Module: nes_button_capture
// PURPOSE
//  Downstream consumer of the NES clock-divider/counter stage. Samples the controller's serial
//  data line on each button_en strobe within a latch-framed read, assembles 8 button bits,
//  and publishes a stable, active-high button vector, a frame-valid pulse and new-press edges
//  to game logic. Runs entirely in the clk domain; nes_data is the only asynchronous input.
// PARAMETERS
//  NUM_BITS     8  serial bits per frame (A,B,Select,Start,Up,Down,Left,Right)
//  SYNC_STAGES  2  flops in nes_data synchronizer (>=2)
// PORTS
//  clk          in   1         system clock
//  rst          in   1         asynchronous, active-high reset
//  latch        in   1         frame latch from counter stage (high at frame start)
//  button_en    in   1         1-clk sample strobe, exactly NUM_BITS per frame
//  finished     in   1         high once the frame's serial window is over
//  nes_data     in   1         controller serial out, active-low, async
//  buttons      out  NUM_BITS  committed button state, 1=pressed, bit0=A .. bit7=Right
//  pressed      out  NUM_BITS  1-clk pulse per bit: newly pressed vs previous commit
//  frame_valid  out  1         1-clk pulse when buttons updates
//  frame_err    out  1         1-clk pulse on aborted/short frame
// BEHAVIOUR
//  - Reset: buttons=0, pressed=0, frame_valid=0, frame_err=0, state=IDLE, bit_cnt=0, shift reg=0,
//    synchronizer flops=1 (idle high = released).
//  - nes_data passes SYNC_STAGES flops -> d_s; sampled value is ~d_s.
//  - latch registered once; latch_rise = latch & ~latch_q.
//  - FSM: IDLE -> SHIFT on latch_rise (bit_cnt<=0, shift reg cleared).
//    SHIFT: on button_en, sr <= {~d_s, sr[NUM_BITS-1:1]}, bit_cnt++; first strobe captures A
//    (strobe may arrive while latch still high). When bit_cnt reaches NUM_BITS -> COMMIT.
//    COMMIT (1 clk): buttons<=sr, pressed<=sr & ~buttons_old, frame_valid=1 -> IDLE.
//  - Latency: frame_valid asserts 2 clk after the 8th button_en (shift, then COMMIT registered).
//  - pressed and frame_valid are registered pulses, 0 on every other cycle.
//  - Boundaries:
//    * latch_rise in SHIFT with bit_cnt<NUM_BITS: frame_err pulse, restart SHIFT with bit_cnt=0.
//    * finished high in SHIFT with bit_cnt<NUM_BITS: frame_err pulse, -> IDLE, buttons held.
//    * button_en in IDLE or COMMIT: ignored.
//    * latch_rise and 8th button_en same clk: strobe wins (frame completes), latch_rise ignored.
//    * Extra strobes after NUM_BITS: impossible in SHIFT (already COMMIT); ignored.
//    * Async rst mid-frame: all state cleared immediately; next frame needs fresh latch_rise.
//  - bit_cnt width $clog2(NUM_BITS+1); no wrap possible.
// CONFIGURATION
//  NES_DEBOUNCE_EN defined: COMMIT updates buttons/pressed/frame_valid only if sr equals the
//   previous frame's sr (stored in cand reg); otherwise cand<=sr, no frame_valid, no error.
//   First frame after reset never commits (cand reset 0 unless sr==0).
//  Not defined: every complete frame commits directly; no cand register.
// STRUCTURE
//  nes_pkg: typedef enum logic [1:0] {IDLE,SHIFT,COMMIT} nes_cap_state_t;
//   localparams BTN_A=0,BTN_B=1,BTN_SELECT=2,BTN_START=3,BTN_UP=4,BTN_DOWN=5,BTN_LEFT=6,BTN_RIGHT=7.
//  Sub-module nes_sync: SYNC_STAGES-deep reset-to-1 synchronizer for nes_data.
// TESTING
//  1 Reset release, no activity -> buttons=8'h00, all pulses 0 for 1000 clk.
//  2 Frame with serial bits (A..Right) 0,1,1,1,1,1,1,0 (A,Right pressed) -> buttons=8'h81,
//    pressed=8'h81, frame_valid 1 clk, 2 clk after 8th strobe.
//  3 Same frame repeated -> buttons=8'h81, pressed=8'h00, frame_valid pulses.
//  4 latch_rise after 3 strobes -> frame_err 1 clk; following full frame (Start only) -> 8'h08.
//  5 finished asserted after 5 strobes -> frame_err, buttons unchanged, state IDLE.
//  6 NES_DEBOUNCE_EN: frames 8'h10,8'h20,8'h20 -> only third commits, buttons=8'h20;
//    without macro each frame commits; rst mid-frame -> outputs 0 within same clk.

Source files
------------

// File: rtl/nes_pkg.sv
// Shared types and constants for the NES controller capture path.
package nes_pkg;

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      COMMIT
   } nes_cap_state_t;

   // Bit positions in the committed button vector (serial order from the pad).
   localparam int BTN_A      = 0;
   localparam int BTN_B      = 1;
   localparam int BTN_SELECT = 2;
   localparam int BTN_START  = 3;
   localparam int BTN_UP     = 4;
   localparam int BTN_DOWN   = 5;
   localparam int BTN_LEFT   = 6;
   localparam int BTN_RIGHT  = 7;

endpackage

// File: rtl/nes_sync.sv
// Multi-flop synchronizer for the controller serial line. Resets to 1 so an
// idle (released) line reads as "no button" straight out of reset.
module nes_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic [SYNC_STAGES-1:0] ff;

   // Shift the asynchronous input through the flop chain.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) ff <= '1;
      else     ff <= {ff[SYNC_STAGES-2:0], d};
   end

   assign q = ff[SYNC_STAGES-1];

endmodule

// File: rtl/nes_button_capture.sv
// NES controller button capture: assembles one serial frame per latch into
// an active-high button vector with frame_valid / pressed / frame_err pulses.
// Optional macro NES_DEBOUNCE_EN: a frame only commits when it matches the
// previous complete frame.
module nes_button_capture
   import nes_pkg::*;
#(
   parameter int NUM_BITS    = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                latch,
   input  logic                button_en,
   input  logic                finished,
   input  logic                nes_data,
   output logic [NUM_BITS-1:0] buttons,
   output logic [NUM_BITS-1:0] pressed,
   output logic                frame_valid,
   output logic                frame_err
);

   localparam int CW = $clog2(NUM_BITS + 1);
   localparam logic [CW-1:0] LAST = CW'(NUM_BITS - 1);

   nes_cap_state_t    state;
   logic [CW-1:0]     bit_cnt;
   logic [NUM_BITS-1:0] sr;
   logic              d_s;
   logic              latch_q;
   logic              latch_rise;

`ifdef NES_DEBOUNCE_EN
   logic [NUM_BITS-1:0] cand;
`endif

   nes_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk (clk),
      .rst (rst),
      .d   (nes_data),
      .q   (d_s)
   );

   // Edge-detect the frame latch from the counter stage.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) latch_q <= 1'b0;
      else     latch_q <= latch;
   end

   assign latch_rise = latch & ~latch_q;

   // Frame FSM: shift in serial bits, then commit the assembled vector.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         bit_cnt     <= '0;
         sr          <= '0;
         buttons     <= '0;
         pressed     <= '0;
         frame_valid <= 1'b0;
         frame_err   <= 1'b0;
`ifdef NES_DEBOUNCE_EN
         cand        <= '0;
`endif
      end else begin
         pressed     <= '0;
         frame_valid <= 1'b0;
         frame_err   <= 1'b0;
         case (state)
            IDLE: begin
               if (latch_rise) begin
                  state   <= SHIFT;
                  bit_cnt <= '0;
                  sr      <= '0;
               end
            end
            SHIFT: begin
               // The final strobe beats a coincident latch edge or finished.
               if (button_en && bit_cnt == LAST) begin
                  sr      <= {~d_s, sr[NUM_BITS-1:1]};
                  bit_cnt <= bit_cnt + CW'(1);
                  state   <= COMMIT;
               end else if (latch_rise) begin
                  frame_err <= 1'b1;
                  bit_cnt   <= '0;
                  sr        <= '0;
               end else if (finished) begin
                  frame_err <= 1'b1;
                  state     <= IDLE;
               end else if (button_en) begin
                  sr      <= {~d_s, sr[NUM_BITS-1:1]};
                  bit_cnt <= bit_cnt + CW'(1);
               end
            end
            COMMIT: begin
               state <= IDLE;
`ifdef NES_DEBOUNCE_EN
               if (sr == cand) begin
                  buttons     <= sr;
                  pressed     <= sr & ~buttons;
                  frame_valid <= 1'b1;
               end else begin
                  cand <= sr;
               end
`else
               buttons     <= sr;
               pressed     <= sr & ~buttons;
               frame_valid <= 1'b1;
`endif
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
